// File: rtl/inert_seq_ctrl_if.sv
// SPI master handshake between the inertial-sensor sequencer and the 16-bit SPI engine.
// The sequencer is the master: it starts transfers, the SPI engine answers with done/rd_data.
interface inert_seq_ctrl_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, output cmd, input done, input rd_data);
    modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/inert_seq_ctrl.sv
// Inertial-sensor sequencer: wake delay, configuration write list, then INT-driven
// multi-channel sample reads published atomically, with an INT watchdog that re-configures.
module inert_seq_ctrl #(
    parameter int                     NUM_CH    = 2,
    parameter int                     INIT_CNT  = 4,
    parameter logic [INIT_CNT*16-1:0] INIT_CMDS = {16'h0D02, 16'h1053, 16'h1150, 16'h1460},
    parameter logic [NUM_CH*7-1:0]    CH_ADDR   = {7'h22, 7'h2C},
    parameter int                     WAKE_BITS = 16,
    parameter int                     TO_BITS   = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   INT,
    inert_seq_ctrl_if.master       spi,
    output logic                   vld,
    output logic [NUM_CH*16-1:0]   data,
    output logic                   cfg_done,
    output logic                   err
);

    localparam int IDX_W = (INIT_CNT > 1) ? $clog2(INIT_CNT) : 1;
    localparam int NBYTE = 2 * NUM_CH;
    localparam int B_W   = $clog2(NBYTE);

    localparam logic [2:0] WAKE      = 3'd0;
    localparam logic [2:0] CFG_ISSUE = 3'd1;
    localparam logic [2:0] CFG_WAIT  = 3'd2;
    localparam logic [2:0] IDLE      = 3'd3;
    localparam logic [2:0] RD_ISSUE  = 3'd4;
    localparam logic [2:0] RD_WAIT   = 3'd5;
    localparam logic [2:0] PUBLISH   = 3'd6;

    logic [2:0]                state;
    logic [WAKE_BITS-1:0]      wake_cnt;
    logic [TO_BITS-1:0]        wd;
    logic [IDX_W-1:0]          idx;
    logic [B_W-1:0]            b;
    logic                      int_meta;
    logic                      int_s;
    logic [NBYTE-1:0][7:0]     stage;
    logic [15:0]               init_cmd;
    logic [6:0]                ch_addr;
    logic [6:0]                rd_addr;
    logic [NUM_CH*16-1:0]      sample;
    logic                      unused_rd_hi;

    // Only the low byte of each SPI read carries register data.
    assign unused_rd_hi = &{1'b0, spi.rd_data[15:8]};

    always_comb begin
        init_cmd = '0;
        for (int i = 0; i < INIT_CNT; i++)
            if (idx == IDX_W'(i))
                init_cmd = INIT_CMDS[(INIT_CNT-1-i)*16 +: 16];
    end

    always_comb begin
        ch_addr = '0;
        for (int i = 0; i < NUM_CH; i++)
            if ((b >> 1) == B_W'(i))
                ch_addr = CH_ADDR[(NUM_CH-1-i)*7 +: 7];
    end

    // High byte lives at the next register address; the 7-bit add wraps.
    assign rd_addr = ch_addr + {6'd0, b[0]};

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_pack
            assign sample[(NUM_CH-1-g)*16 +: 16] = {stage[2*g+1], stage[2*g]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WAKE;
            wake_cnt <= '0;
            wd       <= '0;
            idx      <= '0;
            b        <= '0;
            int_meta <= 1'b0;
            int_s    <= 1'b0;
            stage    <= '0;
            spi.wrt  <= 1'b0;
            spi.cmd  <= '0;
            vld      <= 1'b0;
            data     <= '0;
            cfg_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            int_meta <= INT;
            int_s    <= int_meta;
            spi.wrt  <= 1'b0;
            vld      <= 1'b0;
            case (state)
                WAKE: begin
                    wake_cnt <= wake_cnt + WAKE_BITS'(1);
                    if (&wake_cnt) begin
                        idx   <= '0;
                        state <= CFG_ISSUE;
                    end
                end
                CFG_ISSUE: begin
                    spi.wrt <= 1'b1;
                    spi.cmd <= init_cmd;
                    state   <= CFG_WAIT;
                end
                CFG_WAIT: begin
                    if (spi.done) begin
                        spi.cmd <= '0;
                        if (idx == IDX_W'(INIT_CNT-1)) begin
                            cfg_done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= CFG_ISSUE;
                        end
                    end
                end
                IDLE: begin
                    // INT has priority over a watchdog expiry on the same cycle.
                    if (int_s && en) begin
                        b     <= '0;
                        wd    <= '0;
                        state <= RD_ISSUE;
                    end else if (&wd) begin
                        err      <= 1'b1;
                        cfg_done <= 1'b0;
                        idx      <= '0;
                        wd       <= '0;
                        state    <= CFG_ISSUE;
                    end else if (!en) begin
                        wd <= '0;
                    end else begin
                        wd <= wd + TO_BITS'(1);
                    end
                end
                RD_ISSUE: begin
                    spi.wrt <= 1'b1;
                    spi.cmd <= {1'b1, rd_addr, 8'h00};
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (spi.done) begin
                        stage[b] <= spi.rd_data[7:0];
                        spi.cmd  <= '0;
                        if (b == B_W'(NBYTE-1)) begin
                            state <= PUBLISH;
                        end else begin
                            b     <= b + B_W'(1);
                            state <= RD_ISSUE;
                        end
                    end
                end
                PUBLISH: begin
                    data  <= sample;
                    vld   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= WAKE;
            endcase
        end
    end

endmodule

// File: tb/tb_inert_seq_ctrl.sv
// Scoreboard bench for inert_seq_ctrl: stimulus pushes expected SPI commands and samples,
// a negedge monitor pops and compares them whenever wrt or vld is presented.
module tb_inert_seq_ctrl;
    localparam int SPI_LAT = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic        INT = 1'b0;
    logic        vld;
    logic [31:0] data;
    logic        cfg_done;
    logic        err;

    inert_seq_ctrl_if spi();

    inert_seq_ctrl #(
        .NUM_CH(2), .INIT_CNT(4),
        .INIT_CMDS({16'h0D02, 16'h1053, 16'h1150, 16'h1460}),
        .CH_ADDR({7'h22, 7'h2C}),
        .WAKE_BITS(4), .TO_BITS(6)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .INT(INT), .spi(spi),
        .vld(vld), .data(data), .cfg_done(cfg_done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_cmd[$];
    logic [31:0] exp_data[$];
    logic [7:0]  rd_q[$];

    int wrt_cnt = 0;
    int done_cnt = 0;
    int vld_cnt = 0;
    int first_wrt_cyc = -1;
    int last_done_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cfg();
        exp_cmd.push_back(16'h0D02);
        exp_cmd.push_back(16'h1053);
        exp_cmd.push_back(16'h1150);
        exp_cmd.push_back(16'h1460);
    endtask

    // Bytes in read order: ch0 low, ch0 high, ch1 low, ch1 high.
    task automatic push_sample(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input logic [31:0] exp);
        rd_q.push_back(b0);
        rd_q.push_back(b1);
        rd_q.push_back(b2);
        rd_q.push_back(b3);
        exp_cmd.push_back(16'hA200);
        exp_cmd.push_back(16'hA300);
        exp_cmd.push_back(16'hAC00);
        exp_cmd.push_back(16'hAD00);
        exp_data.push_back(exp);
    endtask

    // SPI engine model: done pulses SPI_LAT cycles after the cycle in which wrt is seen.
    initial begin : spi_model
        logic [15:0] c;
        logic [7:0]  by;
        spi.done    = 1'b0;
        spi.rd_data = 16'h0000;
        forever begin
            step();
            if (spi.wrt === 1'b1) begin
                c = spi.cmd;
                repeat (SPI_LAT) step();
                by = 8'hEE;
                if (c[15] && rd_q.size() > 0) by = rd_q.pop_front();
                spi.done    = 1'b1;
                spi.rd_data = {8'hC3, by};
                step();
                spi.done    = 1'b0;
                spi.rd_data = 16'h0000;
            end
        end
    end

    always @(negedge clk) begin
        if (spi.done === 1'b1) begin
            last_done_cyc = cyc;
            done_cnt++;
        end
        if (spi.wrt === 1'b1) begin
            wrt_cnt++;
            if (first_wrt_cyc < 0) first_wrt_cyc = cyc;
            if (exp_cmd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmd_unexpected: got %h expected no wrt", spi.cmd);
            end else begin
                check("cmd", spi.cmd, exp_cmd.pop_front());
            end
        end
        if (vld === 1'b1) begin
            vld_cnt++;
            // done seen in cycle X -> PUBLISH in X+1 -> registered vld in X+2
            check("vld_latency", cyc - last_done_cyc, 2);
            if (exp_data.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL vld_unexpected: got data %h expected no vld", data);
            end else begin
                check("data", data, exp_data.pop_front());
            end
        end
    end

    initial begin : guard
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int rel, v, e, n;
        int vc[3];

        // Reset state
        repeat (3) step();
        check("rst_wrt", spi.wrt, 0);
        check("rst_cmd", spi.cmd, 0);
        check("rst_vld", vld, 0);
        check("rst_data", data, 0);
        check("rst_cfg_done", cfg_done, 0);
        check("rst_err", err, 0);

        // Config list after wake: 16 WAKE cycles (counter 0..15), 1 CFG_ISSUE, then registered wrt
        push_cfg();
        rst = 1'b0;
        rel = cyc;
        for (int i = 0; i < 400 && !cfg_done; i++) step();
        check("cfg_done_wait", cfg_done, 1);
        check("first_wrt_offset", first_wrt_cyc - rel, 17);
        check("cfg_wrt_count", wrt_cnt, 4);
        check("cfg_done_count", done_cnt, 4);
        check("cfg_done_after_done", cyc - last_done_cyc, 1);
        check("cfg_err", err, 0);
        check("cfg_queue_empty", exp_cmd.size(), 0);

        // One sample from an INT pulse
        push_sample(8'h34, 8'h12, 8'hCD, 8'hAB, 32'h1234_ABCD);
        INT = 1'b1;
        step();
        step();
        INT = 1'b0;
        for (int i = 0; i < 300 && !vld; i++) step();
        check("s1_vld_wait", vld, 1);
        en  = 1'b0;
        INT = 1'b1;
        repeat (3) step();
        check("s1_single_vld", vld_cnt, 1);
        check("s1_queue_empty", exp_cmd.size(), 0);

        // en low with INT high: no reads and the watchdog must not fire
        n = wrt_cnt;
        repeat (1000) step();
        check("en_low_no_wrt", wrt_cnt, n);
        check("en_low_no_err", err, 0);

        // Raise en with INT held: three back-to-back samples
        push_sample(8'h00, 8'hFF, 8'hFF, 8'h00, 32'hFF00_00FF);
        push_sample(8'h01, 8'h80, 8'h7F, 8'hFE, 32'h8001_FE7F);
        push_sample(8'h55, 8'hAA, 8'hA5, 8'h5A, 32'hAA55_5AA5);
        en = 1'b1;
        e  = cyc;
        for (int i = 0; i < 10 && !spi.wrt; i++) step();
        check("en_wrt_seen", spi.wrt, 1);
        check("en_start_within_3", (cyc - e) <= 3, 1);
        n = 0;
        for (int i = 0; i < 600 && n < 3; i++) begin
            step();
            if (vld) begin
                vc[n] = cyc;
                n++;
                if (n == 2) INT = 1'b0;
            end
        end
        check("b2b_vld_count", n, 3);
        // 4 bytes x (10 + 2) + PUBLISH + IDLE
        check("b2b_spacing_1", vc[1] - vc[0], 50);
        check("b2b_spacing_2", vc[2] - vc[1], 50);

        // Watchdog: IDLE wd runs 0..63, expiry on the 64th IDLE cycle after vld
        v = vc[2];
        push_cfg();
        for (int i = 0; i < 200 && !err; i++) step();
        check("wd_err", err, 1);
        check("wd_err_cycle", cyc - v, 64);
        check("wd_cfg_done_cleared", cfg_done, 0);
        for (int i = 0; i < 400 && !cfg_done; i++) step();
        check("wd_reconfig_done", cfg_done, 1);
        check("wd_err_sticky", err, 1);
        check("wd_queue_empty", exp_cmd.size(), 0);

        // Reset during the third read's RD_WAIT
        push_sample(8'h11, 8'h22, 8'h33, 8'h44, 32'h0);
        void'(exp_data.pop_back());
        INT = 1'b1;
        step();
        step();
        INT = 1'b0;
        n = 0;
        for (int i = 0; i < 200 && n < 3; i++) begin
            step();
            if (spi.wrt) n++;
        end
        check("rst_mid_third_wrt", n, 3);
        repeat (3) step();
        rst = 1'b1;
        step();
        check("mid_rst_wrt", spi.wrt, 0);
        check("mid_rst_cmd", spi.cmd, 0);
        check("mid_rst_vld", vld, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_cfg_done", cfg_done, 0);
        check("mid_rst_err", err, 0);
        exp_cmd.delete();
        step();
        rst = 1'b0;
        rel = cyc;
        first_wrt_cyc = -1;
        push_cfg();
        for (int i = 0; i < 400 && !cfg_done; i++) step();
        check("rerst_cfg_done", cfg_done, 1);
        check("rerst_first_wrt_offset", first_wrt_cyc - rel, 17);
        check("rerst_err", err, 0);
        check("rerst_data", data, 0);
        check("rerst_queue_empty", exp_cmd.size(), 0);
        check("total_vld", vld_cnt, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
